data_mem_model: RTL and testbench
=================================

# data_mem_model

Parametrised data-memory slave for the CPU bench, replacing the bench's inline array-and-display memory. It accepts one word-addressed request per cycle with byte enables, returns read data after a configurable fixed latency, and flags out-of-range accesses. A write-log FIFO optionally records every committed store so a checker can drain stores instead of parsing simulation output. It sits between the CPU's M-stage data port and the bench checker.

## Interface
- DEPTH_WORDS, 4096: memory size in 32-bit words; power of two, 16..65536
- BASE_ADDR, 32'h0000_0000: byte address of word 0; word-aligned
- RD_LAT, 1: response latency in cycles, 1..4
- LOG_DEPTH, 16: write-log FIFO entries, power of two, 2..256
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-low
- req_valid  in  1  request present
- req_ready  out  1  request accepted when req_valid & req_ready
- req_addr  in  32  byte address; bits [1:0] ignored
- req_byteen  in  4  byte-write enables; 4'b0000 = read
- req_wdata  in  32  write data in byte lanes
- req_pc  in  32  PC of issuing instruction, logged with stores
- rsp_valid  out  1  one-cycle pulse per accepted request
- rsp_rdata  out  32  read data, or merged word for writes
- rsp_err  out  1  accompanies rsp_valid; address out of range
- log_valid  out  1  log FIFO non-empty
- log_ready  in  1  pop when log_valid & log_ready
- log_pc  out  32  PC of head entry
- log_addr  out  32  aligned byte address of head entry
- log_data  out  32  full merged word written
- log_count  out  $clog2(LOG_DEPTH)+1  current occupancy

## Operation
- Word index = (req_addr - BASE_ADDR) >> 2. The access is in range iff BASE_ADDR <= req_addr < BASE_ADDR + 4*DEPTH_WORDS.
- Accepted write (byteen != 0, in range): the new word takes the enabled bytes from req_wdata and the other bytes from the current word. It commits at the accepting edge. If logging is compiled in, one log entry {req_pc, aligned addr, merged word} is pushed in the same edge.
- Accepted read (byteen == 0, in range): the word is sampled at the accepting edge, so it includes a write accepted on the previous cycle.
- Out of range: the memory is not modified and nothing is logged. Response rdata = 0, rsp_err = 1.
- Every accepted request yields exactly one response. Responses come back in request order through a RD_LAT-stage valid/data/err shift pipeline.
- req_ready = !log_full | log_ready. A pop in the same cycle frees a slot. Reads and out-of-range requests ignore this and are always accepted.
- Log FIFO uses a circular buffer and wrap-around pointers. Pointers wrap modulo LOG_DEPTH. On a simultaneous push and pop, count is unchanged and head/tail both advance.
- Reset (reset == 0 at an edge) does the following:
  - all memory words = 0
  - FIFO emptied, pointers = 0
  - response pipeline cleared
  - any in-flight responses are discarded, with no pulse after reset
  - any request presented in a reset cycle is ignored

## Timing
- Reset values: req_ready 1, rsp_valid 0, rsp_rdata 0, rsp_err 0, log_valid 0, log_pc/log_addr/log_data 0, log_count 0.
- Request accepted at edge N → rsp_valid high during cycle N+RD_LAT (after edge N+RD_LAT-1 for RD_LAT=1: visible the cycle after acceptance). Width is one cycle.
- Back-to-back requests give back-to-back responses; throughput is one per cycle.
- A log entry pushed at edge N gives log_valid high from cycle N+1. The head outputs are registered or FIFO-read with no combinational path from req_*.
- With the FIFO full and log_ready = 0, a write holds req_ready low. The write is accepted on the first cycle log_ready = 1.

## Configuration
- WRITE_LOG_EN defined: the log FIFO, the log_* outputs and store backpressure are present.
- WRITE_LOG_EN undefined: no FIFO storage. log_valid/log_pc/log_addr/log_data/log_count tied 0, log_ready ignored, req_ready tied 1. Memory and response behaviour are identical.

## Test plan
- Reset, then read 0x0000_0010 → rsp_valid after RD_LAT cycles, rdata 0, err 0.
- Write 0x10 byteen 4'b1111 data 0x11223344, then byteen 4'b0010 data 0x0000AA00, then read 0x10 → rdata 0x1122AA44. Log holds two entries: data 0x11223344 then 0x1122AA44.
- RD_LAT=3, four back-to-back reads → four consecutive rsp_valid pulses starting 3 cycles after the first acceptance, in order.
- Write to BASE_ADDR+4*DEPTH_WORDS → rsp_err 1, rdata 0, log_count unchanged, memory unchanged.
- LOG_DEPTH=2, log_ready=0, three writes → third write stalls with req_ready 0. Raising log_ready for one cycle accepts it; log_count stays 2.
- Reset asserted while a RD_LAT=4 read is in flight → no rsp_valid afterwards, all outputs at reset values, log_count 0.

Source files
------------

// File: rtl/data_mem_model.sv
// data_mem_model: word-addressed data memory slave with byte enables, fixed-latency in-order responses
// and range checking. Define WRITE_LOG_EN to build the store-log FIFO and its store backpressure.
module data_mem_model #(
   parameter int unsigned DEPTH_WORDS = 4096,
   parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
   parameter int unsigned RD_LAT      = 1,
   parameter int unsigned LOG_DEPTH   = 16
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         req_valid,
   output logic                         req_ready,
   input  logic [31:0]                  req_addr,
   input  logic [3:0]                   req_byteen,
   input  logic [31:0]                  req_wdata,
   input  logic [31:0]                  req_pc,
   output logic                         rsp_valid,
   output logic [31:0]                  rsp_rdata,
   output logic                         rsp_err,
   output logic                         log_valid,
   input  logic                         log_ready,
   output logic [31:0]                  log_pc,
   output logic [31:0]                  log_addr,
   output logic [31:0]                  log_data,
   output logic [$clog2(LOG_DEPTH):0]   log_count
);

   localparam int unsigned AW   = $clog2(DEPTH_WORDS);
   localparam int unsigned LW   = $clog2(LOG_DEPTH);
   localparam logic [31:0] SPAN = 32'(4 * DEPTH_WORDS);

   logic [31:0]       mem [DEPTH_WORDS];
   logic [31:0]       offset;
   logic              in_range;
   logic              is_write;
   logic              accept;
   logic              commit;
   logic [AW-1:0]     widx;
   logic [31:0]       cur_word;
   logic [31:0]       merged;
   logic [31:0]       rsp_word;

   logic [RD_LAT-1:0] pipe_valid;
   logic [RD_LAT-1:0] pipe_err;
   logic [31:0]       pipe_data [RD_LAT];

   // Request decode: offset arithmetic avoids overflow of BASE_ADDR + span near the top of memory.
   always_comb begin
      offset   = req_addr - BASE_ADDR;
      in_range = (req_addr >= BASE_ADDR) && (offset < SPAN);
      widx     = offset[AW+1:2];
      is_write = (req_byteen != 4'b0000);
      cur_word = mem[widx];
      merged   = cur_word;
      for (int b = 0; b < 4; b++) begin
         if (req_byteen[b]) merged[8*b +: 8] = req_wdata[8*b +: 8];
      end
      accept   = req_valid && (req_ready || !is_write || !in_range);
      commit   = accept && is_write && in_range;
      rsp_word = !in_range ? 32'h0 : (is_write ? merged : cur_word);
   end

   // Memory array and response shift pipeline; stage 0 loads at the accepting edge.
   always_ff @(posedge clk) begin
      if (!reset) begin
         for (int i = 0; i < int'(DEPTH_WORDS); i++) mem[i] <= '0;
         for (int i = 0; i < int'(RD_LAT); i++) pipe_data[i] <= '0;
         pipe_valid <= '0;
         pipe_err   <= '0;
      end else begin
         if (commit) mem[widx] <= merged;
         for (int i = int'(RD_LAT) - 1; i > 0; i--) begin
            pipe_valid[i] <= pipe_valid[i-1];
            pipe_err[i]   <= pipe_err[i-1];
            pipe_data[i]  <= pipe_data[i-1];
         end
         pipe_valid[0] <= accept;
         pipe_err[0]   <= accept && !in_range;
         pipe_data[0]  <= accept ? rsp_word : 32'h0;
      end
   end

   assign rsp_valid = pipe_valid[RD_LAT-1];
   assign rsp_err   = pipe_err[RD_LAT-1];
   assign rsp_rdata = pipe_data[RD_LAT-1];

`ifdef WRITE_LOG_EN
   logic [31:0] lpc_mem  [LOG_DEPTH];
   logic [31:0] ladr_mem [LOG_DEPTH];
   logic [31:0] ldat_mem [LOG_DEPTH];
   logic [LW-1:0] wr_ptr;
   logic [LW-1:0] rd_ptr;
   logic [LW:0]   count;
   logic          log_full;
   logic          push;
   logic          pop;

   assign log_full  = (count == (LW+1)'(LOG_DEPTH));
   assign req_ready = !log_full || log_ready;
   assign pop       = (count != '0) && log_ready;
   assign push      = commit;

   // Circular store log; a same-cycle pop frees the slot a push needs.
   always_ff @(posedge clk) begin
      if (!reset) begin
         for (int i = 0; i < int'(LOG_DEPTH); i++) begin
            lpc_mem[i]  <= '0;
            ladr_mem[i] <= '0;
            ldat_mem[i] <= '0;
         end
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            lpc_mem[wr_ptr]  <= req_pc;
            ladr_mem[wr_ptr] <= {req_addr[31:2], 2'b00};
            ldat_mem[wr_ptr] <= merged;
            wr_ptr           <= wr_ptr + LW'(1);
         end
         if (pop) rd_ptr <= rd_ptr + LW'(1);
         count <= count + (LW+1)'(push) - (LW+1)'(pop);
      end
   end

   assign log_valid = (count != '0);
   assign log_pc    = lpc_mem[rd_ptr];
   assign log_addr  = ladr_mem[rd_ptr];
   assign log_data  = ldat_mem[rd_ptr];
   assign log_count = count;
`else
   logic unused_log;
   assign unused_log = ^{log_ready, req_pc};
   assign req_ready  = 1'b1;
   assign log_valid  = 1'b0;
   assign log_pc     = '0;
   assign log_addr   = '0;
   assign log_data   = '0;
   assign log_count  = '0;
`endif

endmodule

// File: tb/tb_data_mem_model.sv
// tb_data_mem_model: randomized self-checking bench for data_mem_model against a queue/array model.
// Expectations follow WRITE_LOG_EN the same way the design does.
module tb_data_mem_model;

   localparam int unsigned DEPTH  = 64;
   localparam logic [31:0] BASE   = 32'h0000_0400;
   localparam int unsigned LAT    = 3;
   localparam int unsigned LDEPTH = 4;
   localparam int unsigned CW     = $clog2(LDEPTH) + 1;
`ifdef WRITE_LOG_EN
   localparam bit LOG_EN = 1'b1;
`else
   localparam bit LOG_EN = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          reset;
   logic          req_valid;
   logic          req_ready;
   logic [31:0]   req_addr;
   logic [3:0]    req_byteen;
   logic [31:0]   req_wdata;
   logic [31:0]   req_pc;
   logic          rsp_valid;
   logic [31:0]   rsp_rdata;
   logic          rsp_err;
   logic          log_valid;
   logic          log_ready;
   logic [31:0]   log_pc;
   logic [31:0]   log_addr;
   logic [31:0]   log_data;
   logic [CW-1:0] log_count;

   always #5 clk = ~clk;

   data_mem_model #(
      .DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE), .RD_LAT(LAT), .LOG_DEPTH(LDEPTH)
   ) dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
      .req_byteen(req_byteen), .req_wdata(req_wdata), .req_pc(req_pc),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
      .log_valid(log_valid), .log_ready(log_ready), .log_pc(log_pc),
      .log_addr(log_addr), .log_data(log_data), .log_count(log_count)
   );

   typedef struct {int due; logic [31:0] data; logic err;} rsp_t;
   typedef struct {logic [31:0] pc; logic [31:0] addr; logic [31:0] data;} log_t;

   logic [31:0] m_mem [DEPTH];
   rsp_t        rspq[$];
   log_t        logq[$];
   int          pulses[$];
   int          step;
   int          errors;
   int          checks;
   logic [31:0] last_rdata;
   logic        last_err;

   // One clock of the reference model: decide acceptance from the rules, advance, then check outputs.
   task automatic cycle(output bit acc);
      bit              exp_ready, wr, inr, pop, exp_v;
      longint unsigned a;
      int              idx;
      logic [31:0]     word;
      rsp_t            r;
      log_t            e;
      exp_ready = !LOG_EN || (logq.size() < LDEPTH) || (log_ready == 1'b1);
      checks++;
      if (req_ready !== exp_ready) begin
         errors++;
         $display("FAIL req_ready step %0d: got %b want %b", step, req_ready, exp_ready);
      end
      a   = 64'(req_addr);
      inr = (a >= 64'(BASE)) && (a < 64'(BASE) + 64'(4 * DEPTH));
      wr  = (req_byteen != 4'b0000);
      acc = reset && req_valid && (exp_ready || !wr || !inr);
      pop = LOG_EN && reset && log_ready && (logq.size() > 0);
      idx = inr ? int'((a - 64'(BASE)) / 4) : 0;
      word = m_mem[idx];
      for (int b = 0; b < 4; b++) if (req_byteen[b]) word[8*b +: 8] = req_wdata[8*b +: 8];
      @(posedge clk);
      if (!reset) begin
         foreach (m_mem[i]) m_mem[i] = '0;
         rspq.delete();
         logq.delete();
      end else begin
         if (pop) void'(logq.pop_front());
         if (acc) begin
            r.due  = step + int'(LAT) - 1;
            r.data = inr ? word : 32'h0;
            r.err  = !inr;
            if (inr && wr) begin
               m_mem[idx] = word;
               if (LOG_EN) begin
                  e.pc = req_pc; e.addr = req_addr & ~32'h3; e.data = word;
                  logq.push_back(e);
               end
            end
            rspq.push_back(r);
         end
      end
      @(negedge clk);
      while (rspq.size() > 0 && rspq[0].due < step) void'(rspq.pop_front());
      exp_v = (rspq.size() > 0) && (rspq[0].due == step);
      checks++;
      if (rsp_valid !== exp_v) begin
         errors++;
         $display("FAIL rsp_valid step %0d: got %b want %b", step, rsp_valid, exp_v);
      end
      if (exp_v) begin
         checks++;
         if ({rsp_rdata, rsp_err} !== {rspq[0].data, rspq[0].err}) begin
            errors++;
            $display("FAIL rsp_data step %0d: got %h/%b want %h/%b", step, rsp_rdata, rsp_err,
                     rspq[0].data, rspq[0].err);
         end
         void'(rspq.pop_front());
      end
      if (rsp_valid === 1'b1) begin
         last_rdata = rsp_rdata; last_err = rsp_err; pulses.push_back(step);
      end
      checks++;
      if (log_count !== CW'(logq.size()) || log_valid !== (logq.size() > 0)) begin
         errors++;
         $display("FAIL log_count step %0d: got %0d/%b want %0d", step, log_count, log_valid, logq.size());
      end
      if (logq.size() > 0) begin
         checks++;
         if ({log_pc, log_addr, log_data} !== {logq[0].pc, logq[0].addr, logq[0].data}) begin
            errors++;
            $display("FAIL log_head step %0d: got %h %h %h want %h %h %h", step, log_pc, log_addr,
                     log_data, logq[0].pc, logq[0].addr, logq[0].data);
         end
      end
      step++;
   endtask

   task automatic idle(input int n);
      bit acc;
      req_valid = 1'b0;
      for (int i = 0; i < n; i++) cycle(acc);
   endtask

   task automatic req(input logic [31:0] addr, input logic [3:0] be, input logic [31:0] wd,
                      input logic [31:0] pc);
      bit acc;
      int n;
      req_valid = 1'b1; req_addr = addr; req_byteen = be; req_wdata = wd; req_pc = pc;
      acc = 1'b0; n = 0;
      while (!acc && n < 10) begin cycle(acc); n++; end
      if (!acc) begin
         checks++; errors++;
         $display("FAIL req_timeout addr %h: got no accept want accept within 10 cycles", addr);
      end
      req_valid = 1'b0;
   endtask

   task automatic test_reset();
      bit acc;
      reset = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      req_valid = 1'b1; req_addr = BASE; req_byteen = 4'hF; req_wdata = 32'hFFFF_FFFF; req_pc = 32'h1;
      cycle(acc);
      req_valid = 1'b0;
      checks++;
      if ({req_ready, rsp_valid, rsp_rdata, rsp_err, log_valid, log_pc, log_addr, log_data, log_count}
          !== {1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 96'h0, CW'(0)}) begin
         errors++;
         $display("FAIL reset_values: got %b %b %h %b %b %h %h %h %0d want 1 0 0 0 0 0 0 0 0", req_ready,
                  rsp_valid, rsp_rdata, rsp_err, log_valid, log_pc, log_addr, log_data, log_count);
      end
      reset = 1'b1;
   endtask

   task automatic test_read_zero();
      last_rdata = 32'hDEAD_BEEF; last_err = 1'b1;
      req(BASE + 32'h10, 4'h0, 32'h0, 32'h100);
      idle(LAT);
      checks++;
      if (last_rdata !== 32'h0 || last_err !== 1'b0) begin
         errors++;
         $display("FAIL read_zero: got %h/%b want 00000000/0", last_rdata, last_err);
      end
   endtask

   task automatic test_byte_merge();
      log_ready = 1'b1; idle(2);
      log_ready = 1'b0;
      req(BASE + 32'h10, 4'b1111, 32'h1122_3344, 32'h200);
      req(BASE + 32'h10, 4'b0010, 32'h0000_AA00, 32'h204);
      checks++;
      if (log_count !== CW'(LOG_EN ? 2 : 0) || log_data !== (LOG_EN ? 32'h1122_3344 : 32'h0)) begin
         errors++;
         $display("FAIL merge_log_first: got %0d/%h want %0d/%h", log_count, log_data,
                  LOG_EN ? 2 : 0, LOG_EN ? 32'h1122_3344 : 32'h0);
      end
      last_rdata = 32'hDEAD_BEEF;
      req(BASE + 32'h10, 4'b0000, 32'h0, 32'h208);
      idle(LAT);
      checks++;
      if (last_rdata !== 32'h1122_AA44) begin
         errors++;
         $display("FAIL merge_read: got %h want 1122aa44", last_rdata);
      end
      log_ready = 1'b1; idle(1); log_ready = 1'b0;
      checks++;
      if (log_data !== (LOG_EN ? 32'h1122_AA44 : 32'h0)) begin
         errors++;
         $display("FAIL merge_log_second: got %h want %h", log_data, LOG_EN ? 32'h1122_AA44 : 32'h0);
      end
      log_ready = 1'b1; idle(2);
   endtask

   task automatic test_back_to_back();
      int s0;
      log_ready = 1'b1;
      for (int i = 0; i < 4; i++) req(BASE + 32'(8 * i), 4'hF, $urandom, 32'h300 + 32'(i));
      idle(LAT + 1);
      pulses.delete();
      s0 = step;
      for (int i = 0; i < 4; i++) req(BASE + 32'(8 * i), 4'h0, 32'h0, 32'h310);
      idle(LAT + 1);
      checks++;
      if (pulses.size() != 4) begin
         errors++;
         $display("FAIL b2b_count: got %0d pulses want 4", pulses.size());
      end else begin
         for (int i = 0; i < 4; i++) begin
            checks++;
            if (pulses[i] != s0 + int'(LAT) - 1 + i) begin
               errors++;
               $display("FAIL b2b_timing %0d: got step %0d want %0d", i, pulses[i], s0 + int'(LAT) - 1 + i);
            end
         end
      end
   endtask

   task automatic test_out_of_range();
      log_ready = 1'b1; idle(2); log_ready = 1'b0;
      req(BASE + 32'(4 * DEPTH), 4'hF, 32'hFFFF_FFFF, 32'h400);
      idle(LAT);
      checks++;
      if (last_err !== 1'b1 || last_rdata !== 32'h0 || log_count !== CW'(0)) begin
         errors++;
         $display("FAIL oor_high: got err %b rdata %h count %0d want 1 00000000 0", last_err, last_rdata, log_count);
      end
      req(BASE - 32'h4, 4'hF, 32'hFFFF_FFFF, 32'h404);
      idle(LAT);
      checks++;
      if (last_err !== 1'b1 || last_rdata !== 32'h0) begin
         errors++;
         $display("FAIL oor_low: got err %b rdata %h want 1 00000000", last_err, last_rdata);
      end
      req(BASE, 4'h0, 32'h0, 32'h408);
      req(BASE + 32'(4 * DEPTH - 4), 4'h0, 32'h0, 32'h40C);
      idle(LAT);
      checks++;
      if (last_err !== 1'b0) begin
         errors++;
         $display("FAIL last_word_err: got %b want 0", last_err);
      end
   endtask

   task automatic test_backpressure();
      bit acc;
      log_ready = 1'b1; idle(2); log_ready = 1'b0;
      for (int i = 0; i < int'(LDEPTH); i++) req(BASE + 32'(4 * i), 4'hF, $urandom, 32'h500 + 32'(i));
      req_valid = 1'b1; req_addr = BASE + 32'h40; req_byteen = 4'h3; req_wdata = $urandom; req_pc = 32'h5FF;
      checks++;
      if (req_ready !== !LOG_EN) begin
         errors++;
         $display("FAIL bp_stall: got req_ready %b want %b", req_ready, !LOG_EN);
      end
      repeat (3) cycle(acc);
      log_ready = 1'b1;
      cycle(acc);
      log_ready = 1'b0; req_valid = 1'b0;
      checks++;
      if (log_count !== CW'(LOG_EN ? LDEPTH : 0)) begin
         errors++;
         $display("FAIL bp_count: got %0d want %0d", log_count, LOG_EN ? LDEPTH : 0);
      end
      log_ready = 1'b1; idle(LDEPTH + 2);
   endtask

   task automatic test_random();
      bit acc;
      for (int i = 0; i < 400; i++) begin
         req_valid  = ($urandom_range(3, 0) != 0);
         case ($urandom_range(7, 0))
            0:       req_addr = $urandom_range(32'h3FF, 0);
            1:       req_addr = BASE + 32'(4 * DEPTH) + $urandom_range(63, 0);
            default: req_addr = BASE + 32'(4 * $urandom_range(DEPTH - 1, 0)) + $urandom_range(3, 0);
         endcase
         req_byteen = $urandom_range(1, 0) ? 4'(($urandom_range(15, 0))) : 4'h0;
         req_wdata  = $urandom;
         req_pc     = $urandom;
         log_ready  = ($urandom_range(2, 0) == 0);
         cycle(acc);
      end
      log_ready = 1'b1; idle(LDEPTH + LAT + 2);
   endtask

   task automatic test_reset_inflight();
      bit acc;
      log_ready = 1'b0;
      req(BASE + 32'h20, 4'hF, 32'hCAFE_F00D, 32'h600);
      req(BASE + 32'h20, 4'h0, 32'h0, 32'h604);
      reset = 1'b0;
      req_valid = 1'b1; req_byteen = 4'hF; req_addr = BASE; req_wdata = 32'h1234_5678;
      cycle(acc);
      reset = 1'b1;
      idle(LAT + 2);
      checks++;
      if ({req_ready, rsp_valid, rsp_rdata, rsp_err, log_valid, log_pc, log_addr, log_data, log_count}
          !== {1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 96'h0, CW'(0)}) begin
         errors++;
         $display("FAIL inflight_reset: got %b %b %h %b %b %h %h %h %0d want 1 0 0 0 0 0 0 0 0", req_ready,
                  rsp_valid, rsp_rdata, rsp_err, log_valid, log_pc, log_addr, log_data, log_count);
      end
      last_rdata = 32'hDEAD_BEEF;
      req(BASE + 32'h20, 4'h0, 32'h0, 32'h608);
      idle(LAT);
      checks++;
      if (last_rdata !== 32'h0) begin
         errors++;
         $display("FAIL mem_cleared: got %h want 00000000", last_rdata);
      end
   endtask

   initial begin
      errors = 0; checks = 0; step = 0;
      reset = 1'b0; req_valid = 1'b0; req_addr = '0; req_byteen = '0; req_wdata = '0; req_pc = '0;
      log_ready = 1'b0;
      foreach (m_mem[i]) m_mem[i] = '0;
      test_reset();
      test_read_zero();
      test_byte_merge();
      test_back_to_back();
      test_out_of_range();
      test_backpressure();
      test_random();
      test_reset_inflight();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
